// File: rtl/window_generator.sv
// ----------------------------------------------------------------------------
// window_generator: KxK sliding-window builder over a raster pixel stream.
// Optional feature macro: WINDOW_GEN_STRIDE2_EN (stride-2 window selection).
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module window_generator #(
  parameter int IMG_WIDTH   = 28,
  parameter int IMG_HEIGHT  = 28,
  parameter int DATA_WIDTH  = 8,
  parameter int KERNEL_SIZE = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] pix_in,
  input  logic                  pix_valid,
  output logic                  pix_ready,
  output logic [DATA_WIDTH-1:0] window [0:KERNEL_SIZE-1][0:KERNEL_SIZE-1],
  output logic                  win_valid,
  input  logic                  win_ready,
  output logic                  frame_done
);

  localparam int K  = KERNEL_SIZE;
  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
`ifdef WINDOW_GEN_STRIDE2_EN
  localparam int LAST_ROW = (K - 1) + 2 * ((IMG_HEIGHT - K) / 2);
  localparam int LAST_COL = (K - 1) + 2 * ((IMG_WIDTH  - K) / 2);
`else
  localparam int LAST_ROW = IMG_HEIGHT - 1;
  localparam int LAST_COL = IMG_WIDTH  - 1;
`endif

  logic [CW-1:0]         col_q, col_d;
  logic [RW-1:0]         row_q, row_d;
  logic                  win_valid_q, win_valid_d;
  logic                  last_q, last_d;
  logic [DATA_WIDTH-1:0] lb_q  [0:K-2][0:IMG_WIDTH-1];
  logic [DATA_WIDTH-1:0] sw_q  [0:K-1][0:K-1];
  logic [DATA_WIDTH-1:0] sw_d  [0:K-1][0:K-1];
  logic [DATA_WIDTH-1:0] win_q [0:K-1][0:K-1];
  logic                  pix_xfer, win_xfer, in_window, produce;

  assign pix_ready = !win_valid_q || win_ready;
  assign pix_xfer  = pix_valid && pix_ready;
  assign win_xfer  = win_valid_q && win_ready;
  assign in_window = (row_q >= RW'(K - 1)) && (col_q >= CW'(K - 1));

`ifdef WINDOW_GEN_STRIDE2_EN
  // Keep only windows at an even offset from the first full window.
  assign produce = pix_xfer && in_window &&
                   (row_q[0] == 1'((K - 1) % 2)) && (col_q[0] == 1'((K - 1) % 2));
`else
  assign produce = pix_xfer && in_window;
`endif

  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    win_valid_d = win_valid_q;
    last_d      = last_q;
    sw_d        = sw_q;

    if (pix_xfer) begin
      if (col_q == CW'(IMG_WIDTH - 1)) begin
        col_d = '0;
        row_d = (row_q == RW'(IMG_HEIGHT - 1)) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end

    if (produce) begin
      win_valid_d = 1'b1;
      last_d      = (row_q == RW'(LAST_ROW)) && (col_q == CW'(LAST_COL));
    end else if (win_xfer) begin
      win_valid_d = 1'b0;
      last_d      = 1'b0;
    end

    // Shift left; the new right column is the vertical slice at col_q,
    // oldest line-buffer row on top and the incoming pixel at the bottom.
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K - 1; j++) begin
        sw_d[i][j] = sw_q[i][j+1];
      end
    end
    for (int i = 0; i < K - 1; i++) begin
      sw_d[i][K-1] = lb_q[K-2-i][col_q];
    end
    sw_d[K-1][K-1] = pix_in;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_q       <= '0;
      row_q       <= '0;
      win_valid_q <= 1'b0;
      last_q      <= 1'b0;
      for (int i = 0; i < K; i++) begin
        for (int j = 0; j < K; j++) begin
          win_q[i][j] <= '0;
        end
      end
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      win_valid_q <= win_valid_d;
      last_q      <= last_d;
      if (produce) begin
        win_q <= sw_d;
      end
    end
  end

  // Data path holds no reset: row restarts at 0, so stale taps never reach a window.
  always_ff @(posedge clk) begin
    if (pix_xfer) begin
      sw_q            <= sw_d;
      lb_q[0][col_q]  <= pix_in;
      for (int k = 1; k < K - 1; k++) begin
        lb_q[k][col_q] <= lb_q[k-1][col_q];
      end
    end
  end

  assign window     = win_q;
  assign win_valid  = win_valid_q;
  assign frame_done = rst_n && win_xfer && last_q;

endmodule

`default_nettype wire

// File: tb/tb_window_generator.sv
// ----------------------------------------------------------------------------
// tb_window_generator: directed/table-driven bench for window_generator (K=3).
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_window_generator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] pix_in = '0;
  logic       pix_valid = 1'b0;
  logic       win_ready = 1'b0;
  logic       pix_ready, win_valid, frame_done;
  logic [7:0] window [0:2][0:2];

  logic [7:0] d5_pix_in = '0;
  logic       d5_pix_valid = 1'b0;
  logic       d5_pix_ready, d5_win_valid, d5_frame_done;
  logic [7:0] d5_window [0:2][0:2];

  always #5 clk = ~clk;

  window_generator #(.IMG_WIDTH(4), .IMG_HEIGHT(4), .DATA_WIDTH(8), .KERNEL_SIZE(3)) u_dut (
    .clk(clk), .rst_n(rst_n), .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .window(window), .win_valid(win_valid), .win_ready(win_ready), .frame_done(frame_done)
  );

  window_generator #(.IMG_WIDTH(5), .IMG_HEIGHT(5), .DATA_WIDTH(8), .KERNEL_SIZE(3)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .pix_in(d5_pix_in), .pix_valid(d5_pix_valid), .pix_ready(d5_pix_ready),
    .window(d5_window), .win_valid(d5_win_valid), .win_ready(1'b1), .frame_done(d5_frame_done)
  );

  typedef struct {
    int px [9];
    bit last;
  } win_t;

  win_t tbl [4];
  win_t exp_q [$];
  int   stream [$];
  bit   prod [16];
  int   pix_idx, n_vec, n_err, n_win, n_fd;

  task automatic chk(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Evaluates the handshake just before the edge, then advances one clock.
  task automatic cycle();
    win_t e;
    #1;
    if (win_valid && win_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_window", 1, 0);
      end else begin
        e = exp_q.pop_front();
        for (int k = 0; k < 9; k++) chk("window_px", int'(window[k/3][k%3]), e.px[k]);
        chk("frame_done_on_xfer", int'(frame_done), int'(e.last));
      end
      n_win++;
    end else if (frame_done) begin
      chk("frame_done_without_xfer", 1, 0);
    end
    if (frame_done) n_fd++;
    if (pix_valid && pix_ready) pix_idx++;
    @(posedge clk);
    #1;
  endtask

  task automatic start();
    exp_q.delete();
    stream.delete();
    pix_idx = 0;
    n_win   = 0;
    n_fd    = 0;
  endtask

  task automatic push_tbl(input int off);
    win_t e;
    for (int w = 0; w < 4; w++) begin
      e = tbl[w];
      for (int k = 0; k < 9; k++) e.px[k] = e.px[k] + off;
      exp_q.push_back(e);
    end
  endtask

  function automatic int pv(input int f, input int idx);
    return (f * 53 + idx * 29 + 7) % 256;
  endfunction

  task automatic run(input int pv_pct, input int wr_pct, input int budget);
    int cyc;
    cyc = 0;
    while ((pix_idx < stream.size() || exp_q.size() > 0) && cyc < budget) begin
      pix_valid = (pix_idx < stream.size()) && (int'($urandom_range(99)) < pv_pct);
      pix_in    = (pix_idx < stream.size()) ? 8'(stream[pix_idx]) : 8'd0;
      win_ready = int'($urandom_range(99)) < wr_pct;
      cycle();
      cyc++;
    end
    chk("drain_within_budget", int'(cyc < budget), 1);
    pix_valid = 1'b0;
    win_ready = 1'b1;
    cycle();
    cycle();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int tl_exp [$];
    int n5, fd5, cnt;
    win_t e;

    tbl[0].px = '{0, 1, 2, 4, 5, 6, 8, 9, 10};     tbl[0].last = 1'b0;
    tbl[1].px = '{1, 2, 3, 5, 6, 7, 9, 10, 11};    tbl[1].last = 1'b0;
    tbl[2].px = '{4, 5, 6, 8, 9, 10, 12, 13, 14};  tbl[2].last = 1'b0;
    tbl[3].px = '{5, 6, 7, 9, 10, 11, 13, 14, 15}; tbl[3].last = 1'b1;
    for (int i = 0; i < 16; i++) prod[i] = (i == 10) || (i == 11) || (i == 14) || (i == 15);
    n_vec = 0;
    n_err = 0;

    // Reset state, sampled while rst_n is still low
    win_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_win_valid", int'(win_valid), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_pix_ready", int'(pix_ready), 1);
    for (int k = 0; k < 9; k++) chk("rst_window_zero", int'(window[k/3][k%3]), 0);
    rst_n = 1'b1;

    // Single frame, always ready: latency and contents
    start();
    for (int i = 0; i < 16; i++) stream.push_back(i);
    push_tbl(0);
    for (int i = 0; i < 16; i++) begin
      pix_valid = 1'b1;
      pix_in    = 8'(stream[pix_idx]);
      win_ready = 1'b1;
      cycle();
      chk("win_valid_after_pixel", int'(win_valid), int'(prod[i]));
    end
    run(100, 100, 50);
    chk("frame1_windows", n_win, 4);
    chk("frame1_frame_done", n_fd, 1);

    // Backpressure on the first window
    start();
    for (int i = 0; i < 16; i++) stream.push_back(i);
    push_tbl(0);
    cnt = 0;
    while (pix_idx < 11 && cnt < 30) begin
      pix_valid = 1'b1;
      pix_in    = 8'(stream[pix_idx]);
      win_ready = 1'b1;
      cycle();
      cnt++;
    end
    pix_valid = 1'b1;
    pix_in    = 8'(stream[pix_idx]);
    win_ready = 1'b0;
    repeat (5) begin
      #1;
      chk("stall_pix_ready", int'(pix_ready), 0);
      chk("stall_win_valid", int'(win_valid), 1);
      chk("stall_w00", int'(window[0][0]), 0);
      chk("stall_w02", int'(window[0][2]), 2);
      chk("stall_w11", int'(window[1][1]), 5);
      chk("stall_w22", int'(window[2][2]), 10);
      cycle();
    end
    chk("stall_no_pixel_taken", pix_idx, 11);
    run(100, 100, 100);
    chk("stall_windows", n_win, 4);
    chk("stall_frame_done", n_fd, 1);

    // Two back-to-back frames
    start();
    for (int i = 0; i < 16; i++) stream.push_back(i);
    for (int i = 0; i < 16; i++) stream.push_back(100 + i);
    push_tbl(0);
    push_tbl(100);
    run(100, 100, 100);
    chk("b2b_windows", n_win, 8);
    chk("b2b_frame_done", n_fd, 2);

    // Reset after pixel 9, then a clean frame
    start();
    for (int i = 0; i < 10; i++) stream.push_back(i);
    run(100, 100, 50);
    chk("abort_no_windows", n_win, 0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    start();
    for (int i = 0; i < 16; i++) stream.push_back(i);
    push_tbl(0);
    run(100, 100, 100);
    chk("post_reset_windows", n_win, 4);
    chk("post_reset_frame_done", n_fd, 1);

    // Random handshakes over three frames, reference sliding window
    start();
    for (int f = 0; f < 3; f++) begin
      for (int idx = 0; idx < 16; idx++) stream.push_back(pv(f, idx));
      for (int wr = 0; wr < 2; wr++) begin
        for (int wc = 0; wc < 2; wc++) begin
          for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
              e.px[i*3+j] = pv(f, (wr + i) * 4 + wc + j);
          e.last = (wr == 1) && (wc == 1);
          exp_q.push_back(e);
        end
      end
    end
    run(70, 60, 3000);
    chk("random_windows", n_win, 12);
    chk("random_frame_done", n_fd, 3);

    // 5x5 image on the second instance
`ifdef WINDOW_GEN_STRIDE2_EN
    tl_exp = {0, 2, 10, 12};
`else
    tl_exp = {0, 1, 2, 5, 6, 7, 10, 11, 12};
`endif
    n5  = 0;
    fd5 = 0;
    for (int i = 0; i < 27; i++) begin
      d5_pix_valid = (i < 25);
      d5_pix_in    = (i < 25) ? 8'(i) : 8'd0;
      @(posedge clk);
      #1;
      if (d5_win_valid) begin
        if (n5 < tl_exp.size()) begin
          chk("d5_top_left", int'(d5_window[0][0]), tl_exp[n5]);
          chk("d5_mid_left", int'(d5_window[1][0]), tl_exp[n5] + 5);
          chk("d5_top_right", int'(d5_window[0][2]), tl_exp[n5] + 2);
          chk("d5_bottom_right", int'(d5_window[2][2]), tl_exp[n5] + 12);
        end
        n5++;
      end
      if (d5_frame_done) fd5++;
    end
    chk("d5_window_count", n5, tl_exp.size());
    chk("d5_frame_done_count", fd5, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/window_generator.md
WINDOW_GENERATOR -- requirements
Module: window_generator

Interface
REQ-001: The block SHALL take parameter IMG_WIDTH, default 28, as the input image width in pixels (at least KERNEL_SIZE).
REQ-002: The block SHALL take parameter IMG_HEIGHT, default 28, as the input image height in pixels (at least KERNEL_SIZE).
REQ-003: The block SHALL use DATA_WIDTH and KERNEL_SIZE from cnn_defs.svh.
REQ-004: clk  input  1  single clock; all logic samples on the rising edge.
REQ-005: rst_n  input  1  reset, synchronous and active-low.
REQ-006: pix_in  input  DATA_WIDTH  unsigned pixel, raster order (row-major, top-left first).
REQ-007: pix_valid  input  1  pix_in is valid.
REQ-008: pix_ready  output  1  block accepts pix_in this cycle.
REQ-009: window  output  unsigned DATA_WIDTH array [0:KERNEL_SIZE-1][0:KERNEL_SIZE-1]  feature window, same shape as the MAC feature port.
REQ-010: win_valid  output  1  window is valid.
REQ-011: win_ready  input  1  downstream MAC stage accepts window.
REQ-012: frame_done  output  1  one-cycle pulse when the last window of a frame is accepted downstream.

Function
REQ-013: A pixel transfer SHALL occur only on a cycle with pix_valid=1 and pix_ready=1; a window transfer SHALL occur only on a cycle with win_valid=1 and win_ready=1.
REQ-014: The block SHALL hold KERNEL_SIZE-1 line buffers of IMG_WIDTH entries each, plus a KERNEL_SIZE x KERNEL_SIZE shift window fed from the line-buffer taps and pix_in.
REQ-015: Column counter col SHALL advance 0..IMG_WIDTH-1 on each pixel transfer; on wrap it returns to 0 and row increments.
REQ-016: After the pixel at (row=IMG_HEIGHT-1, col=IMG_WIDTH-1), row and col SHALL both wrap to 0, and the next frame SHALL start with no idle cycle required.
REQ-017: A window SHALL be produced on the pixel transfer where row>=KERNEL_SIZE-1 and col>=KERNEL_SIZE-1 (subject to REQ-030).
REQ-018: A produced window SHALL be registered, with win_valid=1 on the cycle after that pixel transfer (latency 1).
REQ-019: Orientation: window[i][j] SHALL equal pixel (row-(KERNEL_SIZE-1)+i, col-(KERNEL_SIZE-1)+j); window[0][0] is top-left.
REQ-020: Output skid depth SHALL be one: pix_ready = !win_valid || win_ready.
REQ-021: win_valid SHALL clear after a window transfer unless a new window is produced in the same cycle.
REQ-022: window and win_valid SHALL remain stable while win_valid=1 and win_ready=0.
REQ-023: Pixels at positions that produce no window SHALL still be accepted whenever pix_ready=1.
REQ-024: The window count per frame SHALL be (IMG_HEIGHT-KERNEL_SIZE+1)*(IMG_WIDTH-KERNEL_SIZE+1) (stride 1).
REQ-025: Pixel values SHALL pass through unmodified; the block performs no arithmetic on data.
REQ-026: Windows SHALL never mix data from two frames or from non-adjacent rows at a row wrap.

Reset
REQ-027: While rst_n=0 at a clock edge: row=0, col=0, win_valid=0, frame_done=0, window all zero, pix_ready=1 on the following cycle.
REQ-028: Line-buffer contents SHALL NOT need reset; no window built from stale data is emitted, because row restarts at 0.
REQ-029: Reset mid-frame SHALL abort the frame; any pending window is dropped without a transfer and without a frame_done pulse.

Configuration
REQ-030: Macro WINDOW_GEN_STRIDE2_EN, when defined, SHALL restrict window production to positions where (row-(KERNEL_SIZE-1)) and (col-(KERNEL_SIZE-1)) are both even.
REQ-031: With WINDOW_GEN_STRIDE2_EN defined, the count per frame SHALL be ceil((IMG_HEIGHT-KERNEL_SIZE+1)/2)*ceil((IMG_WIDTH-KERNEL_SIZE+1)/2), and frame_done SHALL mark the last strided window.
REQ-032: Without WINDOW_GEN_STRIDE2_EN, the block SHALL use stride 1 only, and no stride logic SHALL be present.

Verification
REQ-033: 4x4 image, KERNEL_SIZE=3, pixels 0..15, win_ready=1 -> 4 windows; the first window is [[0,1,2],[4,5,6],[8,9,10]], one cycle after pixel 10; the last window is [[5,6,7],[9,10,11],[13,14,15]], with frame_done pulsed once.
REQ-034: Same image with win_ready=0 for 5 cycles while the first window is valid -> pix_ready=0 and the window is held unchanged; when win_ready rises, the sequence continues with no window lost.
REQ-035: Two back-to-back 4x4 frames (second frame 100..115) -> 8 windows; the 5th window is [[100,101,102],[104,105,106],[108,109,110]], with no cross-frame values.
REQ-036: rst_n=0 asserted after pixel 9 of a frame, then a full new frame 0..15 -> exactly 4 correct windows and one frame_done pulse.
REQ-037: WINDOW_GEN_STRIDE2_EN defined, 5x5 image with pixels 0..24 -> 4 windows with top-left pixels 0, 2, 10, 12 (for example, [[10,11,12],[15,16,17],[20,21,22]]); without the macro -> 9 windows.
REQ-038: Random pix_valid and win_ready toggling over 3 frames -> every window matches the reference-model sliding window in order, and no window is duplicated.
